// File: rtl/mpi_if.sv
// mpi_if -- asynchronous Q-bus style slave handshake bundle.
//   sync/din/dout/wtbt/ad_in : driven by the bus master (CPU side)
//   ad_out/ad_oe/rply        : driven by the slave
interface mpi_if;
    logic        sync;
    logic        din;
    logic        dout;
    logic        wtbt;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic        rply;

    modport master (output sync, din, dout, wtbt, ad_in,
                    input  ad_out, ad_oe, rply);
    modport slave  (input  sync, din, dout, wtbt, ad_in,
                    output ad_out, ad_oe, rply);
endinterface

// File: rtl/mpi_slave.sv
// mpi_slave -- bus slave decoding a 32-byte register window and converting
// asynchronous SYNC/DIN/DOUT cycles into single-clock local read/write strobes.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   bus_init         bus INIT, synchronous abort (holds outputs cleared)
//   bus              mpi_if.slave: sync/din/dout/wtbt/ad_in in, ad_out/ad_oe/rply out
//   loc_addr         word index inside the window
//   loc_re/loc_rdata one-clock read request; data returned the following clock
//   loc_we/loc_be/loc_wdata one-clock write strobe with byte enables
module mpi_slave #(
    parameter logic [15:0] BASE      = 16'o177600,
    parameter int unsigned WAIT_RPLY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_init,
    mpi_if.slave        bus,
    output logic [3:0]  loc_addr,
    output logic        loc_re,
    input  logic [15:0] loc_rdata,
    output logic        loc_we,
    output logic [1:0]  loc_be,
    output logic [15:0] loc_wdata
);

    localparam logic [1:0] WAIT_N = WAIT_RPLY[1:0];

    typedef enum logic [2:0] {
        IDLE, ADDR, RD_REQ, RD_WAIT, RD_RPLY, WR, WR_RPLY, DONE
    } state_t;

    state_t      state, state_n;
    logic [1:0]  sync_ff, din_ff, dout_ff, wtbt_ff;
    logic        sync_d;
    logic        sync_s, din_s, dout_s, wtbt_s, sync_rise, hit;
    logic        rply_q, ad_oe_q;
    logic [15:0] ad_out_q;
    logic [1:0]  wcnt;
    logic        byte_hi;
    // Address-phase WTBT is kept for visibility only; no decision depends on it.
    logic        addr_wtbt_unused;

    // Two-flop synchronizers. Not touched by bus_init so a held SYNC
    // does not look like a fresh edge once INIT releases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
            din_ff  <= '0;
            dout_ff <= '0;
            wtbt_ff <= '0;
            sync_d  <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], bus.sync};
            din_ff  <= {din_ff[0],  bus.din};
            dout_ff <= {dout_ff[0], bus.dout};
            wtbt_ff <= {wtbt_ff[0], bus.wtbt};
            sync_d  <= sync_ff[1];
        end
    end

    assign sync_s    = sync_ff[1];
    assign din_s     = din_ff[1];
    assign dout_s    = dout_ff[1];
    assign wtbt_s    = wtbt_ff[1];
    assign sync_rise = sync_s & ~sync_d;
    assign hit       = (bus.ad_in[15:5] == BASE[15:5]);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (sync_rise) state_n = hit ? ADDR : DONE;
            ADDR:    if (din_s) state_n = RD_REQ;
                     else if (dout_s) state_n = WR;
            RD_REQ:  state_n = RD_WAIT;
            RD_WAIT: if (wcnt == WAIT_N) state_n = RD_RPLY;
            RD_RPLY: if (!din_s) state_n = ADDR;
            WR:      state_n = WR_RPLY;
            WR_RPLY: if (!dout_s) state_n = ADDR;
            DONE:    if (!sync_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Losing SYNC aborts whatever is in flight.
        if (state != IDLE && !sync_s) state_n = IDLE;
    end

    // Outputs are registered from the next state so they are glitch-free
    // and line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rply_q           <= 1'b0;
            ad_oe_q          <= 1'b0;
            ad_out_q         <= '0;
            loc_re           <= 1'b0;
            loc_we           <= 1'b0;
            loc_be           <= '0;
            loc_wdata        <= '0;
            loc_addr         <= '0;
            wcnt             <= '0;
            byte_hi          <= 1'b0;
            addr_wtbt_unused <= 1'b0;
        end else if (bus_init) begin
            state            <= IDLE;
            rply_q           <= 1'b0;
            ad_oe_q          <= 1'b0;
            ad_out_q         <= '0;
            loc_re           <= 1'b0;
            loc_we           <= 1'b0;
            loc_be           <= '0;
            loc_wdata        <= '0;
            loc_addr         <= '0;
            wcnt             <= '0;
            byte_hi          <= 1'b0;
            addr_wtbt_unused <= 1'b0;
        end else begin
            state   <= state_n;
            rply_q  <= (state_n == RD_RPLY) || (state_n == WR_RPLY);
            ad_oe_q <= (state_n == RD_RPLY);
            loc_re  <= (state_n == RD_REQ);
            loc_we  <= (state == WR) && (state_n == WR_RPLY);
            wcnt    <= (state == RD_WAIT) ? wcnt + 2'd1 : 2'd0;

            if (state == IDLE && sync_rise && hit) begin
                loc_addr         <= bus.ad_in[4:1];
                byte_hi          <= bus.ad_in[0];
                addr_wtbt_unused <= wtbt_s;
            end

            // loc_rdata is valid on the first RD_WAIT clock; extra wait
            // clocks only delay RPLY.
            if (state == RD_WAIT && wcnt == 2'd0)
                ad_out_q <= loc_rdata;

            if (state == WR && state_n == WR_RPLY) begin
                if (!wtbt_s) begin
                    loc_be    <= 2'b11;
                    loc_wdata <= bus.ad_in;
                end else if (!byte_hi) begin
                    loc_be    <= 2'b01;
                    loc_wdata <= {8'h00, bus.ad_in[7:0]};
                end else begin
                    loc_be    <= 2'b10;
                    loc_wdata <= {bus.ad_in[15:8], 8'h00};
                end
            end
        end
    end

    assign bus.rply   = rply_q;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.ad_out = ad_out_q;

endmodule
